// File: rtl/ad9866_pkg.sv
// Shared types and constants for the AD9866 SPI configuration master.
// The default init table holds the seven AD9866 registers written after reset.
package ad9866_pkg;

  localparam int AD9866_INIT_LEN  = 20;
  localparam int AD9866_GAP_CLKS  = 2;

  typedef struct packed {
    logic       rw;
    logic [1:0] bc;
    logic [4:0] addr;
    logic [7:0] data;
  } spi_frame_t;

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } init_entry_t;

  typedef struct packed {
    logic       rd;
    logic [4:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  // Entry index is the register address; bit8 marks entries that are written.
  localparam logic [0:AD9866_INIT_LEN-1][8:0] AD9866_INIT_DEFAULT = {
    9'h180, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h121,
    9'h14B, 9'h000, 9'h000, 9'h120, 9'h141, 9'h101, 9'h000, 9'h000,
    9'h000, 9'h100, 9'h000, 9'h000
  };

endpackage

// File: rtl/ad9866_cmd_fifo.sv
// Host command queue for the AD9866 SPI master: DEPTH entries of cmd_t,
// push ignored when full, pop ignored when empty, head always visible.
module ad9866_cmd_fifo
  import ad9866_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// AD9866 SPI configuration master: init table playback, gain auto-update, queued host access.
// Define AD9866_READBACK_EN to enable register reads over sdo; otherwise reads are dropped.
module ad9866_spi_ctrl
  import ad9866_pkg::*;
#(
  parameter int                          INIT_LEN   = AD9866_INIT_LEN,
  parameter logic [0:INIT_LEN-1][8:0]    INIT_TABLE = AD9866_INIT_DEFAULT,
  parameter int                          CLK_DIV    = 1,
  parameter int                          FIFO_DEPTH = 4,
  parameter logic [4:0]                  GAIN_ADDR  = 5'h0A
)(
  input  logic       clk,
  input  logic       reset_n,
  output logic       sclk,
  output logic       sen_n,
  output logic       sdio,
  input  logic       sdo,
  input  logic [5:0] gain,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       init_done,
  output logic       busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(INIT_LEN + 1);

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [1:0]       gap_cnt;
  logic [IDX_W-1:0] idx;
  logic [15:0]      tx;
  logic [5:0]       gain_last;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  cmd_t             cmd_in, fifo_head;
  init_entry_t      entry;
  spi_frame_t       frame;
  logic             start_frame, init_last, gain_pend, bit_end, frame_end, gap_end;

  assign cmd_in.rd   = cmd_rd;
  assign cmd_in.addr = cmd_addr;
  assign cmd_in.data = cmd_data;
  assign cmd_ready   = !fifo_full;
  assign fifo_push   = cmd_valid && !fifo_full;

  ad9866_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sdio      = tx[15];
  assign init_last = (idx == IDX_W'(INIT_LEN));
  assign entry     = INIT_TABLE[idx];
  assign gain_pend = init_done && (gain != gain_last);
  assign bit_end   = (state == S_SHIFT) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_end = bit_end && sclk && (bit_cnt == 4'd15);
  assign gap_end   = (gap_cnt == 2'(AD9866_GAP_CLKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
    frame       = '0;
    case (state)
      S_INIT: begin
        if (init_last) begin
          state_next = S_IDLE;
        end else if (entry.we) begin
          start_frame = 1'b1;
          frame.addr  = 5'(idx);
          frame.data  = entry.data;
          state_next  = S_SHIFT;
        end
      end
      S_IDLE: begin
        if (gain_pend) begin
          start_frame = 1'b1;
          frame.addr  = GAIN_ADDR;
          frame.data  = {2'b00, gain};
          state_next  = S_SHIFT;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef AD9866_READBACK_EN
          start_frame = 1'b1;
          frame.rw    = fifo_head.rd;
          frame.addr  = fifo_head.addr;
          frame.data  = fifo_head.rd ? 8'h00 : fifo_head.data;
          state_next  = S_SHIFT;
`else
          if (!fifo_head.rd) begin
            start_frame = 1'b1;
            frame.addr  = fifo_head.addr;
            frame.data  = fifo_head.data;
            state_next  = S_SHIFT;
          end
`endif
        end
      end
      S_SHIFT: if (frame_end) state_next = S_GAP;
      S_GAP:   if (gap_end) state_next = (init_done || init_last) ? S_IDLE : S_INIT;
      default: state_next = S_INIT;
    endcase
  end

  // busy is registered, so it follows the FSM/queue/gain status one clock later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk      <= 1'b0;
      sen_n     <= 1'b1;
      tx        <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
      gain_last <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state != S_IDLE) || !fifo_empty || gain_pend;
      if (state == S_INIT && !init_last) idx <= idx + 1'b1;
      if (state == S_IDLE && gain_pend) gain_last <= gain;
      if (!init_done && init_last && (state == S_INIT || (state == S_GAP && gap_end)))
        init_done <= 1'b1;
      if (start_frame) begin
        tx      <= frame;
        sen_n   <= 1'b0;
        sclk    <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end
      if (state == S_SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          sclk    <= !sclk;
          if (sclk) begin
            tx <= {tx[14:0], 1'b0};
            if (bit_cnt == 4'd15) sen_n <= 1'b1;
            else                  bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (frame_end)           gap_cnt <= '0;
      else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end

`ifdef AD9866_READBACK_EN
  logic [7:0] rx;
  logic       rd_pending;

  // sdo is captured on every sclk fall; only read frames publish it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx         <= '0;
      rd_pending <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (bit_end && sclk) rx <= {rx[6:0], sdo};
      if (start_frame) rd_pending <= frame.rw;
      if (state == S_GAP && rd_pending) begin
        rsp_valid  <= 1'b1;
        rsp_data   <= rx;
        rd_pending <= 1'b0;
      end
    end
  end
`else
  logic unused_sdo;
  assign unused_sdo = sdo;
  assign rsp_valid  = 1'b0;
  assign rsp_data   = 8'h00;
`endif

endmodule
